// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: operation select and defaults.
package program_sequencer_pkg;

   localparam int DEF_PC_WIDTH     = 16;
   localparam int DEF_OFF_WIDTH    = 8;
   localparam int DEF_STACK_DEPTH  = 8;
   localparam int DEF_RESET_VECTOR = 0;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_INC  = 3'd1,
      OP_JUMP = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } op_e;

   // Fixed-priority request decode: Ret > Call > Jump > Increment > hold.
   // Stall sits above all of these and is applied by the caller.
   function automatic op_e decode_op(input logic ret, input logic call,
                                     input logic jump, input logic inc);
      if (ret)       return OP_RET;
      else if (call) return OP_CALL;
      else if (jump) return OP_JUMP;
      else if (inc)  return OP_INC;
      else           return OP_HOLD;
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Request/status bundle between a controller (master) and the sequencer (slave).
// i_/o_ prefixes are from the sequencer's point of view.
interface program_sequencer_if
   import program_sequencer_pkg::*;
#(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int OFF_WIDTH   = DEF_OFF_WIDTH,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   logic                 i_stall;
   logic                 i_inc;
   logic [OFF_WIDTH-1:0] i_offset;
   logic                 i_jump;
   logic [PC_WIDTH-1:0]  i_jump_addr;
   logic                 i_call;
   logic                 i_ret;
   logic                 i_clear_err;

   logic [PC_WIDTH-1:0]  o_pc;
   logic [DEPTH_W-1:0]   o_depth;
   logic                 o_stack_full;
   logic                 o_stack_empty;
   logic                 o_overflow;
   logic                 o_underflow;

   modport master (
      output i_stall, i_inc, i_offset, i_jump, i_jump_addr, i_call, i_ret, i_clear_err,
      input  o_pc, o_depth, o_stack_full, o_stack_empty, o_overflow, o_underflow
   );

   modport slave (
      input  i_stall, i_inc, i_offset, i_jump, i_jump_addr, i_call, i_ret, i_clear_err,
      output o_pc, o_depth, o_stack_full, o_stack_empty, o_overflow, o_underflow
   );

endinterface

// File: rtl/program_sequencer_stack.sv
// LIFO return-address stack. Push and pop are ignored when full / empty
// respectively; the sequencer never asserts both in one cycle.
module return_stack #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [DATA_W-1:0]            i_data,
   output logic [DATA_W-1:0]            o_top,
   output logic [$clog2(DEPTH):0]       o_depth,
   output logic                         o_full,
   output logic                         o_empty
);
   localparam int AW      = $clog2(DEPTH);
   localparam int DEPTH_W = AW + 1;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [DEPTH_W-1:0] r_depth;
   logic [AW-1:0]      w_wr_ptr;
   logic [AW-1:0]      w_top_ptr;

   // DEPTH is a power of two, so the low bits of the count address the next
   // free slot, and wrap correctly to DEPTH-1 for the top entry when full.
   assign w_wr_ptr  = r_depth[AW-1:0];
   assign w_top_ptr = w_wr_ptr - AW'(1);

   assign o_top   = r_mem[w_top_ptr];
   assign o_depth = r_depth;
   assign o_full  = (r_depth == DEPTH_W'(DEPTH));
   assign o_empty = (r_depth == '0);

   // Entry storage; contents are never cleared since slots above the count
   // are not observable.
   always_ff @(posedge clk) begin
      if (i_push && !o_full) r_mem[w_wr_ptr] <= i_data;
   end

   // Occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_depth <= '0;
      else if (i_push && !o_full)  r_depth <= r_depth + DEPTH_W'(1);
      else if (i_pop && !o_empty)  r_depth <= r_depth - DEPTH_W'(1);
   end

endmodule

// File: rtl/program_sequencer.sv
// Program counter sequencer: prioritised increment/jump/call/return with a
// return-address stack and sticky overflow/underflow flags.
// OFF_WIDTH must not exceed PC_WIDTH; STACK_DEPTH must be a power of two >= 2.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
   parameter int                  OFF_WIDTH    = DEF_OFF_WIDTH,
   parameter int                  STACK_DEPTH  = DEF_STACK_DEPTH,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR)
) (
   input  logic              clk,
   input  logic              rst,
   program_sequencer_if.slave bus
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   op_e                 w_op;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [PC_WIDTH-1:0] w_off_sx;
   logic [PC_WIDTH-1:0] w_ret_addr;
   logic [PC_WIDTH-1:0] w_top;
   logic [DEPTH_W-1:0]  w_depth;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_ovf_set;
   logic                w_unf_set;
   logic                r_ovf;
   logic                r_unf;

   // Stall masks every request, so a stalled cycle decodes as a hold.
   assign w_op       = bus.i_stall ? OP_HOLD
                                   : decode_op(bus.i_ret, bus.i_call, bus.i_jump, bus.i_inc);
   assign w_off_sx   = PC_WIDTH'($signed(bus.i_offset));
   assign w_ret_addr = r_pc + PC_WIDTH'(1);

   return_stack #(
      .DATA_W (PC_WIDTH),
      .DEPTH  (STACK_DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_ret_addr),
      .o_top   (w_top),
      .o_depth (w_depth),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Execute the selected operation: next PC, stack strobes, error events.
   always_comb begin
      w_pc_nxt  = r_pc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      case (w_op)
         OP_RET: begin
            if (!w_empty) begin
               w_pop    = 1'b1;
               w_pc_nxt = w_top;
            end else begin
               w_unf_set = 1'b1;
            end
         end
         OP_CALL: begin
            if (!w_full) begin
               w_push   = 1'b1;
               w_pc_nxt = bus.i_jump_addr;
            end else begin
               w_ovf_set = 1'b1;
            end
         end
         OP_JUMP: w_pc_nxt = bus.i_jump_addr;
         OP_INC:  w_pc_nxt = r_pc + w_off_sx;
         default: w_pc_nxt = r_pc;
      endcase
   end

   // Program counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pc <= RESET_VECTOR;
      else     r_pc <= w_pc_nxt;
   end

   // Sticky error flags; a new error in the same cycle beats ClearErr, and
   // a stall freezes them (ClearErr included).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (!bus.i_stall) begin
         r_ovf <= w_ovf_set | (r_ovf & ~bus.i_clear_err);
         r_unf <= w_unf_set | (r_unf & ~bus.i_clear_err);
      end
   end

   assign bus.o_pc          = r_pc;
   assign bus.o_depth       = w_depth;
   assign bus.o_stack_full  = w_full;
   assign bus.o_stack_empty = w_empty;
   assign bus.o_overflow    = r_ovf;
   assign bus.o_underflow   = r_unf;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_program_sequencer;
   localparam int PW = 16;
   localparam int OW = 8;
   localparam int SD = 8;
   localparam logic [PW-1:0] RV = 16'h0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   program_sequencer_if #(.PC_WIDTH(PW), .OFF_WIDTH(OW), .STACK_DEPTH(SD)) bus ();

   program_sequencer #(
      .PC_WIDTH(PW), .OFF_WIDTH(OW), .STACK_DEPTH(SD), .RESET_VECTOR(RV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_stk[$];
   logic          m_ovf;
   logic          m_unf;
   bit            cmp_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One clock edge of the architectural behaviour.
   task automatic model_edge();
      bit ovf_ev, unf_ev;
      ovf_ev = 1'b0;
      unf_ev = 1'b0;
      if (bus.i_stall) return;
      if (bus.i_ret) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else                  unf_ev = 1'b1;
      end else if (bus.i_call) begin
         if (m_stk.size() < SD) begin
            m_stk.push_back(PW'(int'(m_pc) + 1));
            m_pc = bus.i_jump_addr;
         end else ovf_ev = 1'b1;
      end else if (bus.i_jump) begin
         m_pc = bus.i_jump_addr;
      end else if (bus.i_inc) begin
         m_pc = PW'(int'(m_pc) + int'($signed(bus.i_offset)));
      end
      if (bus.i_clear_err) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (ovf_ev) m_ovf = 1'b1;
      if (unf_ev) m_unf = 1'b1;
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("pc",    32'(bus.o_pc),          32'(m_pc));
         check("depth", 32'(bus.o_depth),       32'(m_stk.size()));
         check("full",  32'(bus.o_stack_full),  32'(m_stk.size() == SD));
         check("empty", 32'(bus.o_stack_empty), 32'(m_stk.size() == 0));
         check("ovf",   32'(bus.o_overflow),    32'(m_ovf));
         check("unf",   32'(bus.o_underflow),   32'(m_unf));
      end
   end

   task automatic drive(input bit st, input bit inc, input logic [OW-1:0] off,
                        input bit jmp, input logic [PW-1:0] addr,
                        input bit cl, input bit rt, input bit ce);
      bus.i_stall     = st;
      bus.i_inc       = inc;
      bus.i_offset    = off;
      bus.i_jump      = jmp;
      bus.i_jump_addr = addr;
      bus.i_call      = cl;
      bus.i_ret       = rt;
      bus.i_clear_err = ce;
   endtask

   // Apply one request for one edge; returns at the following negedge.
   task automatic cyc(input bit st, input bit inc, input logic [OW-1:0] off,
                      input bit jmp, input logic [PW-1:0] addr,
                      input bit cl, input bit rt, input bit ce);
      drive(st, inc, off, jmp, addr, cl, rt, ce);
      @(posedge clk);
      #1 model_edge();
      @(negedge clk);
   endtask

   task automatic idle(); cyc(0, 0, 8'h00, 0, 16'h0, 0, 0, 0); endtask
   task automatic inc(input logic [OW-1:0] o); cyc(0, 1, o, 0, 16'h0, 0, 0, 0); endtask
   task automatic jump(input logic [PW-1:0] a); cyc(0, 0, 8'h00, 1, a, 0, 0, 0); endtask
   task automatic call(input logic [PW-1:0] a); cyc(0, 0, 8'h00, 0, a, 1, 0, 0); endtask
   task automatic ret(); cyc(0, 0, 8'h00, 0, 16'h0, 0, 1, 0); endtask
   task automatic clr(); cyc(0, 0, 8'h00, 0, 16'h0, 0, 0, 1); endtask

   // Reset lands after a Call is presented but before its edge.
   task automatic reset_mid_call(input logic [PW-1:0] a);
      drive(0, 0, 8'h00, 0, a, 1, 0, 0);
      #2 rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 8'h00, 0, 16'h0, 0, 0, 0);
      model_reset();
      rst = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      // Reset state
      check("rst_pc",    32'(bus.o_pc), 32'h0000);
      check("rst_depth", 32'(bus.o_depth), 32'd0);
      check("rst_flags", 32'({bus.o_overflow, bus.o_underflow}), 32'd0);
      rst = 1'b0;

      // Forward increments
      for (int i = 1; i <= 3; i++) begin
         inc(8'h05);
         check("inc_fwd", 32'(bus.o_pc), 32'(5 * i));
      end

      // Backward wrap and forward wrap
      jump(16'h0002);
      inc(8'hFD);
      check("inc_bwd_wrap", 32'(bus.o_pc), 32'h0000FFFF);
      inc(8'h01);
      check("inc_fwd_wrap", 32'(bus.o_pc), 32'h00000000);

      // Nested call / return
      jump(16'h0010);
      call(16'h0200);
      check("call1_pc", 32'(bus.o_pc), 32'h0200);
      check("call1_depth", 32'(bus.o_depth), 32'd1);
      call(16'h0300);
      check("call2_depth", 32'(bus.o_depth), 32'd2);
      ret();
      check("ret1_pc", 32'(bus.o_pc), 32'h0201);
      ret();
      check("ret2_pc", 32'(bus.o_pc), 32'h0011);
      check("ret2_depth", 32'(bus.o_depth), 32'd0);
      check("ret2_empty", 32'(bus.o_stack_empty), 32'd1);

      // Fill, overflow, clear
      jump(16'h0050);
      for (int i = 0; i < SD; i++) call(PW'(16'h0100 + i));
      check("fill_full", 32'(bus.o_stack_full), 32'd1);
      call(16'h1234);
      check("ovf_pc", 32'(bus.o_pc), 32'h0107);
      check("ovf_flag", 32'(bus.o_overflow), 32'd1);
      check("ovf_depth", 32'(bus.o_depth), 32'd8);
      clr();
      check("ovf_clear", 32'(bus.o_overflow), 32'd0);
      for (int i = 0; i < SD; i++) ret();
      check("drain_pc", 32'(bus.o_pc), 32'h0051);

      // Underflow, stall, call+ret
      ret();
      check("unf_flag", 32'(bus.o_underflow), 32'd1);
      check("unf_pc", 32'(bus.o_pc), 32'h0051);
      cyc(1, 0, 8'h00, 1, 16'hBEEF, 0, 0, 1);
      check("stall_pc", 32'(bus.o_pc), 32'h0051);
      check("stall_keeps_flag", 32'(bus.o_underflow), 32'd1);
      cyc(0, 0, 8'h00, 0, 16'h0, 0, 1, 1);
      check("clr_vs_new_err", 32'(bus.o_underflow), 32'd1);
      clr();
      call(16'h0400);
      cyc(0, 0, 8'h00, 0, 16'h0999, 1, 1, 0);
      check("callret_pc", 32'(bus.o_pc), 32'h0052);
      check("callret_depth", 32'(bus.o_depth), 32'd0);
      check("callret_noovf", 32'(bus.o_overflow), 32'd0);

      // Reset between call request and edge
      call(16'h0600);
      reset_mid_call(16'h0777);
      check("midrst_pc", 32'(bus.o_pc), 32'(RV));
      check("midrst_depth", 32'(bus.o_depth), 32'd0);
      check("midrst_flags", 32'({bus.o_overflow, bus.o_underflow}), 32'd0);
      call(16'h0777);
      check("post_rst_call", 32'(bus.o_pc), 32'h0777);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_mid_call(PW'($urandom));
         end else begin
            cyc($urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 0,
                OW'($urandom),
                $urandom_range(0, 9) == 0,
                PW'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0);
         end
      end

      idle();
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16, program counter width in bits.
REQ-002 Parameter OFF_WIDTH, default 8, signed relative-branch offset width; SHALL be less than or equal to PC_WIDTH.
REQ-003 Parameter STACK_DEPTH, default 8, return-address stack entries; SHALL be a power of two, at least 2.
REQ-004 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-005 Clock  in  1  single clock; all state updates on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 Stall  in  1  freeze all state when high.
REQ-008 Increment  in  1  relative step request.
REQ-009 Offset  in  OFF_WIDTH  two's-complement step for Increment.
REQ-010 Jump  in  1  absolute load request.
REQ-011 JumpAddr  in  PC_WIDTH  target for Jump and Call.
REQ-012 Call  in  1  push return address, then load JumpAddr.
REQ-013 Ret  in  1  pop return address into PC.
REQ-014 ClearErr  in  1  clear sticky error flags.
REQ-015 PC  out  PC_WIDTH  current program counter, registered.
REQ-016 Depth  out  clog2(STACK_DEPTH)+1  occupied stack entries.
REQ-017 StackFull / StackEmpty  out  1 each  Depth==STACK_DEPTH / Depth==0, combinational from Depth.
REQ-018 Overflow / Underflow  out  1 each  sticky error flags, registered.

Function
REQ-019 Per cycle, exactly one operation SHALL take effect, by priority: Stall > Ret > Call > Jump > Increment > hold.
REQ-020 Stall: PC, stack, Depth and error flags hold; ClearErr is ignored.
REQ-021 Increment: PC <= PC + sign-extended Offset, modulo 2^PC_WIDTH (wrap-around, no flag).
REQ-022 Jump: PC <= JumpAddr; stack unchanged.
REQ-023 Call with stack not full: push (PC+1 mod 2^PC_WIDTH), Depth+1, PC <= JumpAddr, all in the same edge.
REQ-024 Call with stack full: no push, PC holds, Overflow <= 1.
REQ-025 Ret with stack not empty: PC <= top entry, Depth-1.
REQ-026 Ret with stack empty: PC holds, Underflow <= 1.
REQ-027 Call and Ret both high: Ret wins and Call is dropped with no side effect.
REQ-028 Hold (no request): all state unchanged.
REQ-029 ClearErr (not stalled) SHALL clear both flags; if an error condition occurs in the same cycle, the new error SHALL win (flag set).
REQ-030 Latency: every effect is visible on PC/Depth/flags one edge after the request; no combinational path from request inputs to PC.
REQ-031 Stack SHALL be LIFO; entries above Depth are don't-care and never observable.

Reset
REQ-032 On Reset high, asynchronously: PC=RESET_VECTOR, Depth=0, Overflow=0, Underflow=0; stack contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL abandon any pending push/pop; the first edge after deassertion executes normally.

Structure
REQ-034 A shared package SHALL hold the operation-select enumeration (HOLD, INC, JUMP, CALL, RET) and default parameter constants.
REQ-035 The stack SHALL be a sub-module return_stack (push, pop, data in/out, Depth), with priority decode and PC register in program_sequencer.

Verification
REQ-036 Reset, then Increment with Offset=8'h05 for 3 cycles -> PC 0x0000, 0x0005, 0x000A, 0x000F.
REQ-037 PC=0x0002, Increment with Offset=8'hFD -> PC=0xFFFF (backward wrap); then Offset=8'h01 -> PC=0x0000.
REQ-038 PC=0x0010, Call JumpAddr=0x0200 -> PC=0x0200, Depth=1; Call 0x0300 -> Depth=2; Ret -> PC=0x0201; Ret -> PC=0x0011, Depth=0, StackEmpty=1.
REQ-039 Fill 8 Calls, 9th Call JumpAddr=0x1234 -> PC unchanged, Overflow=1, Depth=8; ClearErr -> Overflow=0.
REQ-040 Ret on empty stack -> Underflow=1, PC unchanged; Stall with Jump=1 -> PC unchanged; Call+Ret together at Depth=1 -> pop only.
REQ-041 Assert Reset between Call request and edge -> PC=RESET_VECTOR, Depth=0, flags 0.
